qpu_exu_flush_arb: RTL

- Arbitrates pipeline-flush requests from several EXU sources (branch-mispredict resolver, commit-side exception/fence sources) onto the single IFU flush interface (req/ack plus add_op1/add_op2).
- Registers the winning request's PC adder operands and holds them stable until IFU acknowledges.
- Acks the granted source, then enforces a programmable drain gap before the next grant.
- Sits between the commit logic and the IFU.

---
 rtl/qpu_exu_flush_arb_if.sv | 39 +++
 rtl/qpu_exu_flush_arb.sv | 111 +++++++++++
 2 files changed

// File: rtl/qpu_exu_flush_arb_if.sv
// Flush handshake bundle between the EXU flush sources, the flush arbiter and the IFU.
// The arbiter uses the slave modport; the sources/IFU side uses master.
interface qpu_exu_flush_arb_if #(
  parameter int unsigned PC_SIZE = 32,
  parameter int unsigned CNT_W   = 16
);
  logic               src0_flush_req;
  logic [PC_SIZE-1:0] src0_flush_add_op1;
  logic [PC_SIZE-1:0] src0_flush_add_op2;
  logic               src0_flush_ack;
  logic               src1_flush_req;
  logic [PC_SIZE-1:0] src1_flush_add_op1;
  logic [PC_SIZE-1:0] src1_flush_add_op2;
  logic               src1_flush_ack;
  logic               pipe_flush_req;
  logic [PC_SIZE-1:0] pipe_flush_add_op1;
  logic [PC_SIZE-1:0] pipe_flush_add_op2;
  logic               pipe_flush_ack;
  logic               flush_busy;
  logic [CNT_W-1:0]   flush_cnt;

  modport slave (
    input  src0_flush_req, src0_flush_add_op1, src0_flush_add_op2,
    input  src1_flush_req, src1_flush_add_op1, src1_flush_add_op2,
    input  pipe_flush_ack,
    output src0_flush_ack, src1_flush_ack,
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
    output flush_busy, flush_cnt
  );

  modport master (
    output src0_flush_req, src0_flush_add_op1, src0_flush_add_op2,
    output src1_flush_req, src1_flush_add_op1, src1_flush_add_op2,
    output pipe_flush_ack,
    input  src0_flush_ack, src1_flush_ack,
    input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
    input  flush_busy, flush_cnt
  );
endinterface

// File: rtl/qpu_exu_flush_arb.sv
// Fixed-priority arbiter of EXU flush requests onto the single IFU flush port,
// with a programmable drain gap after each accepted flush.
module qpu_exu_flush_arb #(
  parameter int unsigned PC_SIZE   = 32,
  parameter int unsigned FLUSH_GAP = 2,
  parameter int unsigned CNT_W     = 16
) (
  input logic                clk,
  input logic                rst_n,
  qpu_exu_flush_arb_if.slave bus
);
  localparam int unsigned     GAP_W    = 4;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(FLUSH_GAP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state,    w_state_nxt;
  logic [GAP_W-1:0]   r_gap_cnt,  w_gap_cnt_nxt;
  logic               r_grant_id, w_grant_id_nxt;
  logic [PC_SIZE-1:0] r_op1,      w_op1_nxt;
  logic [PC_SIZE-1:0] r_op2,      w_op2_nxt;
  logic               r_req,      w_req_nxt;
  logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
  logic               w_ack;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gap_cnt  <= '0;
      r_grant_id <= 1'b0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_req      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_op1      <= w_op1_nxt;
      r_op2      <= w_op2_nxt;
      r_req      <= w_req_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Next-state: grant only from IDLE, so BUSY never gets preempted
  always_comb begin
    w_state_nxt    = r_state;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_grant_id_nxt = r_grant_id;
    w_op1_nxt      = r_op1;
    w_op2_nxt      = r_op2;
    w_req_nxt      = r_req;
    w_cnt_nxt      = r_cnt;
    w_ack          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.src0_flush_req) begin
          w_grant_id_nxt = 1'b0;
          w_op1_nxt      = bus.src0_flush_add_op1;
          w_op2_nxt      = bus.src0_flush_add_op2;
          w_req_nxt      = 1'b1;
          w_state_nxt    = ST_BUSY;
        end else if (bus.src1_flush_req) begin
          w_grant_id_nxt = 1'b1;
          w_op1_nxt      = bus.src1_flush_add_op1;
          w_op2_nxt      = bus.src1_flush_add_op2;
          w_req_nxt      = 1'b1;
          w_state_nxt    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_ack = bus.pipe_flush_ack;
        if (bus.pipe_flush_ack) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_req_nxt = 1'b0;
          if (GAP_LOAD != '0) begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = GAP_LOAD;
          end else begin
            w_state_nxt   = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        if (r_gap_cnt <= GAP_W'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  assign bus.src0_flush_ack     = w_ack & ~r_grant_id;
  assign bus.src1_flush_ack     = w_ack &  r_grant_id;
  assign bus.pipe_flush_req     = r_req;
  assign bus.pipe_flush_add_op1 = r_op1;
  assign bus.pipe_flush_add_op2 = r_op2;
  assign bus.flush_busy         = (r_state != ST_IDLE);
  assign bus.flush_cnt          = r_cnt;
endmodule
